// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM: clear-sequencer
// state encoding and the legal read-latency settings.
package dual_port_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_t;

  localparam int RL_COMB = 0;
  localparam int RL_REG  = 1;

  function automatic logic is_legal_latency(input int lat);
    return (lat == RL_COMB) || (lat == RL_REG);
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Sweeps every address once after reset or on request so the array has a
// known value; busy marks the cycles in which it owns the write path.
module ram_clear_sequencer
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clockPulse,
  input  logic                  resetN,
  input  logic                  clearStart,
  output logic                  clearWrite,
  output logic [ADDR_WIDTH-1:0] clearAddr,
  output logic                  busy,
  output clear_state_t          clearState
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  clear_state_t          state;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Termination is by compare against the last address, so the counter is
  // parked at zero ready for the next request instead of relying on wrap.
  always_ff @(posedge clockPulse or negedge resetN) begin
    if (!resetN) begin
      state  <= ST_CLEAR;
      addr_q <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            state  <= ST_IDLE;
            addr_q <= '0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clearStart) begin
            state  <= ST_CLEAR;
            addr_q <= '0;
          end
        end
        default: begin
          state  <= ST_CLEAR;
          addr_q <= '0;
        end
      endcase
    end
  end

  assign clearWrite = (state == ST_CLEAR);
  assign busy       = (state == ST_CLEAR);
  assign clearAddr  = addr_q;
  assign clearState = state;

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port RAM with selectable read latency, port-A-wins collision
// handling with a registered flag, and a built-in clear sweep.
module dual_port_ram_param
  import dual_port_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    READ_LATENCY = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clockPulse,
  input  logic                  resetN,
  input  logic                  aWriteEnable,
  input  logic [ADDR_WIDTH-1:0] aAddress,
  input  logic [DATA_WIDTH-1:0] aWriteData,
  output logic [DATA_WIDTH-1:0] aReadData,
  input  logic                  bWriteEnable,
  input  logic [ADDR_WIDTH-1:0] bAddress,
  input  logic [DATA_WIDTH-1:0] bWriteData,
  output logic [DATA_WIDTH-1:0] bReadData,
  input  logic                  clearStart,
  output logic                  busy,
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (!is_legal_latency(READ_LATENCY)) begin : g_bad_latency
    $error("dual_port_ram_param: READ_LATENCY must be 0 or 1");
  end

  logic                  clear_write;
  logic [ADDR_WIDTH-1:0] clear_addr;
  clear_state_t          clear_state;
  logic                  clearing;

  ram_clear_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear (
    .clockPulse(clockPulse),
    .resetN    (resetN),
    .clearStart(clearStart),
    .clearWrite(clear_write),
    .clearAddr (clear_addr),
    .busy      (busy),
    .clearState(clear_state)
  );

  assign clearing = (clear_state == ST_CLEAR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  wr_b;
  logic                  same_addr_dual;

  // While the sweep runs it replaces port A entirely and user writes are dropped.
  assign wr_a   = clearing ? clear_write : aWriteEnable;
  assign addr_a = clearing ? clear_addr  : aAddress;
  assign data_a = clearing ? CLEAR_VALUE : aWriteData;

  assign same_addr_dual = aWriteEnable && bWriteEnable && (aAddress == bAddress);
  assign wr_b           = bWriteEnable && !clearing && !same_addr_dual;

  always_ff @(posedge clockPulse) begin
    if (wr_b) begin
      mem[bAddress] <= bWriteData;
    end
    if (wr_a) begin
      mem[addr_a] <= data_a;
    end
  end

  always_ff @(posedge clockPulse or negedge resetN) begin
    if (!resetN) begin
      collision <= 1'b0;
    end else begin
      collision <= same_addr_dual && !clearing;
    end
  end

  if (READ_LATENCY == RL_REG) begin : g_reg_read
    logic [DATA_WIDTH-1:0] a_rd_q;
    logic [DATA_WIDTH-1:0] b_rd_q;

    // Read-first: the register samples the word as it was before this edge's write.
    always_ff @(posedge clockPulse or negedge resetN) begin
      if (!resetN) begin
        a_rd_q <= '0;
        b_rd_q <= '0;
      end else begin
        a_rd_q <= mem[aAddress];
        b_rd_q <= mem[bAddress];
      end
    end

    assign aReadData = a_rd_q;
    assign bReadData = b_rd_q;
  end else begin : g_comb_read
    assign aReadData = mem[aAddress];
    assign bReadData = mem[bAddress];
  end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: one combinational-read instance clearing to 0 and one
// registered-read instance clearing to FFFF, driven by shared stimulus.
module tb_dual_port_ram_param;

  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wd;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wd;
  logic          clear_start;

  logic [DW-1:0] a_rd0, b_rd0, a_rd1, b_rd1;
  logic          busy0, busy1, coll0, coll1;

  int checks = 0;
  int errors = 0;
  int n;

  dual_port_ram_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(0), .CLEAR_VALUE(16'h0000)
  ) dut0 (
    .clockPulse(clk), .resetN(rst_n),
    .aWriteEnable(a_we), .aAddress(a_addr), .aWriteData(a_wd), .aReadData(a_rd0),
    .bWriteEnable(b_we), .bAddress(b_addr), .bWriteData(b_wd), .bReadData(b_rd0),
    .clearStart(clear_start), .busy(busy0), .collision(coll0)
  );

  dual_port_ram_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_VALUE(16'hFFFF)
  ) dut1 (
    .clockPulse(clk), .resetN(rst_n),
    .aWriteEnable(a_we), .aAddress(a_addr), .aWriteData(a_wd), .aReadData(a_rd1),
    .bWriteEnable(b_we), .bAddress(b_addr), .bWriteData(b_wd), .bReadData(b_rd1),
    .clearStart(clear_start), .busy(busy1), .collision(coll1)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_we = 1'b0; b_we = 1'b0; clear_start = 1'b0;
    a_wd = '0;   b_wd = '0;
  endtask

  // Counts edges until busy drops, bounded so a stuck sequencer still ends the run.
  task automatic count_sweep(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (busy0 && cycles < 200);
  endtask

  initial begin
    rst_n = 1'b0;
    a_addr = '0; b_addr = '0;
    idle_inputs();

    // Reset state
    repeat (3) step();
    check("rst_busy0", busy0, 1);
    check("rst_busy1", busy1, 1);
    check("rst_coll0", coll0, 0);
    check("rst_rd1_a", a_rd1, 16'h0000);
    check("rst_rd1_b", b_rd1, 16'h0000);

    // Power-up sweep length
    rst_n = 1'b1;
    count_sweep(n);
    check("sweep_len", n, 64);
    check("sweep_busy1", busy1, 0);

    // Every address holds its clear value
    for (int i = 0; i < 64; i++) begin
      a_addr = AW'(i);
      b_addr = AW'(63 - i);
      step();
      check("clr_a0", a_rd0, 16'h0000);
      check("clr_b0", b_rd0, 16'h0000);
      check("clr_a1", a_rd1, 16'hFFFF);
      check("clr_b1", b_rd1, 16'hFFFF);
    end

    // Independent dual write
    a_we = 1'b1; a_addr = 6'd5;  a_wd = 16'hBEEF;
    b_we = 1'b1; b_addr = 6'd40; b_wd = 16'h1234;
    step();
    idle_inputs();
    check("indep_no_coll", coll0, 0);
    a_addr = 6'd40; b_addr = 6'd5;
    #1;
    check("indep_a0", a_rd0, 16'h1234);
    check("indep_b0", b_rd0, 16'hBEEF);
    step();
    check("indep_a1", a_rd1, 16'h1234);
    check("indep_b1", b_rd1, 16'hBEEF);

    // Same-address collision, port A wins
    a_we = 1'b1; a_addr = 6'd7; a_wd = 16'hAAAA;
    b_we = 1'b1; b_addr = 6'd7; b_wd = 16'h5555;
    step();
    idle_inputs();
    check("coll_pulse0", coll0, 1);
    check("coll_pulse1", coll1, 1);
    step();
    check("coll_drop0", coll0, 0);
    check("coll_data0", a_rd0, 16'hAAAA);
    check("coll_data1", b_rd1, 16'hAAAA);

    // Read-first on the registered instance
    a_we = 1'b1; a_addr = 6'd3; a_wd = 16'h0001;
    step();
    a_wd = 16'h0002; b_addr = 6'd3;
    step();
    a_we = 1'b0;
    check("rdfirst_old1", b_rd1, 16'h0001);
    check("rdfirst_now0", b_rd0, 16'h0002);
    step();
    check("rdfirst_new1", b_rd1, 16'h0002);

    // Requested clear with writes and a second request while busy
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check("req_busy0", busy0, 1);
    check("req_busy1", busy1, 1);
    n = 0;
    while (busy0 && n < 200) begin
      a_we = (n == 30); a_addr = 6'd10; a_wd = 16'h0000;
      b_we = (n == 31); b_addr = 6'd11; b_wd = 16'h0F0F;
      clear_start = (n == 40);
      step();
      n++;
    end
    idle_inputs();
    check("req_sweep_len", n, 64);
    a_addr = 6'd10; b_addr = 6'd11;
    #1;
    check("busy_wr_a0", a_rd0, 16'h0000);
    check("busy_wr_b0", b_rd0, 16'h0000);
    step();
    check("busy_wr_a1", a_rd1, 16'hFFFF);
    check("busy_wr_b1", b_rd1, 16'hFFFF);
    a_addr = 6'd5;
    step();
    check("reclr_5_0", a_rd0, 16'h0000);
    check("reclr_5_1", a_rd1, 16'hFFFF);
    check("idle_busy0", busy0, 0);

    // Reset mid-sweep restarts from address 0
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 1);
    check("mid_rst_rd1", b_rd1, 16'h0000);
    repeat (2) step();
    rst_n = 1'b1;
    count_sweep(n);
    check("mid_rst_sweep", n, 64);

    // Reset from idle raises busy without a clock edge
    rst_n = 1'b0;
    #1;
    check("async_busy0", busy0, 1);
    check("async_busy1", busy1, 1);
    check("async_rd1", a_rd1, 16'h0000);
    step();
    rst_n = 1'b1;
    count_sweep(n);
    check("post_rst_sweep", n, 64);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
